// File: rtl/chess_clock_ctrl_pkg.sv
// Shared types for the chess clock: FSM states, player encoding, time width.
package chess_clock_ctrl_pkg;

  localparam int SECS_W = 12;

  typedef enum logic [2:0] {
    CLK_IDLE,
    CLK_RUN_WHITE,
    CLK_RUN_BLACK,
    CLK_PAUSED,
    CLK_TIMEOUT
  } clock_state_t;

  typedef enum logic {
    WHITE = 1'b0,
    BLACK = 1'b1
  } player_t;

  // Add with saturation at the top of the time range.
  function automatic logic [SECS_W-1:0] sat_inc(input logic [SECS_W-1:0] v, input int inc);
    logic [SECS_W:0] s;
    s = {1'b0, v} + (SECS_W+1)'(inc);
    return s[SECS_W] ? '1 : s[SECS_W-1:0];
  endfunction

endpackage

// File: rtl/chess_clock_ctrl_sec_prescaler.sv
// One-second prescaler: counts 0..CLK_FREQ_HZ-1 while enabled, pulses tick at terminal count.
module sec_prescaler #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_FREQ_HZ);
  localparam logic [CW-1:0] TERM = CW'(CLK_FREQ_HZ - 1);

  logic [CW-1:0] cnt;

  // A clear in the same cycle swallows the terminal-count tick.
  assign tick = en && !clr && (cnt == TERM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= (cnt == TERM) ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/chess_clock_ctrl.sv
// Two-player chess clock / turn sequencer with sticky timeout flags.
// Define CHESS_CLOCK_INCREMENT_EN to add INC_SECONDS to the mover's time on each move.
module chess_clock_ctrl
  import chess_clock_ctrl_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int START_SECONDS = 600,
  parameter int INC_SECONDS   = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              move_done,
  input  logic              pause,
  input  logic              local_is_white,
  output logic              turn,
  output logic [SECS_W-1:0] white_secs,
  output logic [SECS_W-1:0] black_secs,
  output logic              running,
  output logic              timeout_won,
  output logic              timeout_lost,
  output logic              tick_1hz
);

`ifdef CHESS_CLOCK_INCREMENT_EN
  localparam bit INC_EN = 1'b1;
`else
  localparam bit INC_EN = 1'b0;
`endif

  localparam logic [SECS_W-1:0] START_T = SECS_W'(START_SECONDS);

  clock_state_t      state, state_n;
  player_t           turn_q, turn_n, side;
  logic [SECS_W-1:0] white_q, white_n, black_q, black_n, act;
  logic              won_q, won_n, lost_q, lost_n;
  logic              lw_q, lw_n;
  logic              presc_en, presc_clr, presc_tick;

  assign presc_en  = (state == CLK_RUN_WHITE) || (state == CLK_RUN_BLACK);
  assign presc_clr = (state == CLK_IDLE) || (state == CLK_TIMEOUT) || (presc_en && move_done);

  sec_prescaler #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_presc (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (presc_en),
    .clr     (presc_clr),
    .tick    (presc_tick)
  );

  always_comb begin
    state_n = state;
    turn_n  = turn_q;
    white_n = white_q;
    black_n = black_q;
    won_n   = won_q;
    lost_n  = lost_q;
    lw_n    = lw_q;
    side    = (state == CLK_RUN_BLACK) ? BLACK : WHITE;
    act     = (side == BLACK) ? black_q : white_q;
    case (state)
      CLK_IDLE: begin
        if (start) begin
          state_n = CLK_RUN_WHITE;
          turn_n  = WHITE;
          lw_n    = local_is_white;
          white_n = START_T;
          black_n = START_T;
        end
      end
      CLK_RUN_WHITE, CLK_RUN_BLACK: begin
        if (move_done) begin
          // Move wins over a coincident tick; the pending second is dropped.
          turn_n  = (side == WHITE) ? BLACK : WHITE;
          state_n = pause ? CLK_PAUSED : ((side == WHITE) ? CLK_RUN_BLACK : CLK_RUN_WHITE);
          if (INC_EN) begin
            if (side == WHITE) white_n = sat_inc(white_q, INC_SECONDS);
            else               black_n = sat_inc(black_q, INC_SECONDS);
          end
        end else begin
          if (presc_tick) begin
            if (side == WHITE) white_n = white_q - 1'b1;
            else               black_n = black_q - 1'b1;
            if (act == SECS_W'(1)) begin
              state_n = CLK_TIMEOUT;
              if ((side == WHITE) == lw_q) lost_n = 1'b1;
              else                         won_n  = 1'b1;
            end
          end
          if (pause && (state_n != CLK_TIMEOUT)) state_n = CLK_PAUSED;
        end
      end
      // turn always names the side to resume, so it doubles as the saved side.
      CLK_PAUSED: begin
        if (pause) state_n = (turn_q == BLACK) ? CLK_RUN_BLACK : CLK_RUN_WHITE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CLK_IDLE;
      turn_q   <= WHITE;
      white_q  <= START_T;
      black_q  <= START_T;
      won_q    <= 1'b0;
      lost_q   <= 1'b0;
      lw_q     <= 1'b1;
      tick_1hz <= 1'b0;
    end else begin
      state    <= state_n;
      turn_q   <= turn_n;
      white_q  <= white_n;
      black_q  <= black_n;
      won_q    <= won_n;
      lost_q   <= lost_n;
      lw_q     <= lw_n;
      tick_1hz <= presc_tick;
    end
  end

  assign turn         = turn_q;
  assign white_secs   = white_q;
  assign black_secs   = black_q;
  assign running      = presc_en;
  assign timeout_won  = won_q;
  assign timeout_lost = lost_q;

endmodule
